// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the memory stage.
package mem_pkg;

    localparam int NUM_LANES = 4;
    localparam int XLEN      = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    // Bus request as presented to memory, plus what the load path needs later.
    typedef struct packed {
        logic                 we;
        logic                 load;
        logic [XLEN-1:0]      addr;
        logic [NUM_LANES-1:0] be;
        logic [XLEN-1:0]      wdata;
        logic [2:0]           funct3;
        logic [1:0]           off;
    } mem_req_t;

    // funct3[1:0] carries the size: 00 byte, 01 half, anything else word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [NUM_LANES-1:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of the read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'd0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'd0, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-bus requests, stalls on wait states and
// owns the M/W pipeline register.
module mem_stage
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic                 MemReadM,
    input  logic [1:0]           ResultSrcM,
    input  logic [2:0]           Funct3M,
    input  logic [XLEN-1:0]      ALUResultM,
    input  logic [XLEN-1:0]      WriteDataM,
    input  logic [XLEN-1:0]      PCPlus4M,
    input  logic [4:0]           RdM,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [NUM_LANES-1:0] mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_ready,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 StallM,
    output logic                 RegWriteW,
    output logic                 MisalignW,
    output logic [1:0]           ResultSrcW,
    output logic [XLEN-1:0]      ALUResultW,
    output logic [XLEN-1:0]      ReadDataW,
    output logic [XLEN-1:0]      PCPlus4W,
    output logic [4:0]           RdW
);

    mem_state_t      state, state_n;
    mem_req_t        cur, lat_q;
    logic            run_q;
    logic            access, misalign;
    logic            lat_load, done_load;
    logic [1:0]      sel_off;
    logic [2:0]      sel_f3;
    logic [XLEN-1:0] ld_data;

    assign access   = MemReadM | MemWriteM;
    assign misalign = access & is_misaligned(Funct3M, ALUResultM[1:0]);

    always_comb begin
        cur.we     = MemWriteM;
        cur.load   = MemReadM;
        cur.addr   = {ALUResultM[31:2], 2'b00};
        cur.be     = byte_en(Funct3M, ALUResultM[1:0]);
        cur.wdata  = store_data(Funct3M, WriteDataM);
        cur.funct3 = Funct3M;
        cur.off    = ALUResultM[1:0];
    end

    // run_q keeps the first access off the bus until a clock edge has seen rst_n high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run_q <= 1'b0;
            lat_q <= '0;
        end else begin
            state <= state_n;
            run_q <= 1'b1;
            if (lat_load) lat_q <= cur;
        end
    end

    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cur.addr;
        mem_be    = cur.be;
        mem_wdata = cur.wdata;
        StallM    = 1'b0;
        lat_load  = 1'b0;
        done_load = 1'b0;
        sel_off   = cur.off;
        sel_f3    = cur.funct3;
        case (state)
            IDLE: begin
                if (access && !misalign) begin
                    if (!run_q) begin
                        StallM = rst_n;
                    end else begin
                        mem_req = 1'b1;
                        mem_we  = MemWriteM;
                        if (mem_ready) begin
                            done_load = MemReadM;
                        end else begin
                            StallM   = 1'b1;
                            lat_load = 1'b1;
                            state_n  = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // Bus is driven from the captured request so it cannot move while waiting.
                mem_req   = 1'b1;
                mem_we    = lat_q.we;
                mem_addr  = lat_q.addr;
                mem_be    = lat_q.be;
                mem_wdata = lat_q.wdata;
                sel_off   = lat_q.off;
                sel_f3    = lat_q.funct3;
                if (mem_ready) begin
                    done_load = lat_q.load;
                    state_n   = IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (sel_off),
        .funct3 (sel_f3),
        .data   (ld_data)
    );

    // Stall cycles push a bubble; payload fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & (RdM != 5'd0) & ~misalign;
            MisalignW  <= misalign;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= done_load ? ld_data : '0;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
        end
    end

endmodule
